// File: rtl/segment_scan_controller.sv
// Two-digit seven-segment scan controller with frame-aligned shadow digit updates.
// Define SEG_GHOST_BLANK_EN to insert all-off blanking gaps after each digit.
module segment_scan_controller #(
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] right_digit,
  input  logic [3:0] left_digit,
  input  logic       upd_valid,
  output logic       upd_ready,
  output logic       a0,
  output logic       a1,
  output logic [6:0] cathode,
  output logic       frame_tick
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DRIVE_R = 3'd1;
  localparam logic [2:0] DRIVE_L = 3'd3;
`ifdef SEG_GHOST_BLANK_EN
  localparam logic [2:0] BLANK_R = 3'd2;
  localparam logic [2:0] BLANK_L = 3'd4;
`endif

  logic [2:0]    state, nstate;
  logic [CW-1:0] cnt;
  logic [3:0]    rsh, lsh, nr, nl;
  logic          dwell_end, frame_end, xfer;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  assign dwell_end = (cnt == CW'(DWELL_CYCLES - 1));

`ifdef SEG_GHOST_BLANK_EN
  logic blank_end;
  assign blank_end = (cnt == CW'(BLANK_CYCLES - 1));
  assign frame_end = (state == BLANK_L) && blank_end;
`else
  assign frame_end = (state == DRIVE_L) && dwell_end;
`endif

  assign upd_ready = (state == IDLE) || frame_end;
  assign xfer      = upd_valid && upd_ready;
  // new digits must reach the registered cathode on the very edge they are captured
  assign nr        = xfer ? right_digit : rsh;
  assign nl        = xfer ? left_digit  : lsh;

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = DRIVE_R;
`ifdef SEG_GHOST_BLANK_EN
      DRIVE_R: if (dwell_end) nstate = BLANK_R;
      BLANK_R: if (blank_end) nstate = DRIVE_L;
      DRIVE_L: if (dwell_end) nstate = BLANK_L;
      BLANK_L: if (blank_end) nstate = DRIVE_R;
`else
      DRIVE_R: if (dwell_end) nstate = DRIVE_L;
      DRIVE_L: if (dwell_end) nstate = DRIVE_R;
`endif
      default: nstate = IDLE;
    endcase
    if (!enable) nstate = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rsh        <= '0;
      lsh        <= '0;
      a0         <= 1'b1;
      a1         <= 1'b1;
      cathode    <= 7'h7F;
      frame_tick <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= (nstate != state || nstate == IDLE) ? '0 : cnt + CW'(1);
      if (xfer) begin
        rsh <= right_digit;
        lsh <= left_digit;
      end
      a0 <= (nstate != DRIVE_R);
      a1 <= (nstate != DRIVE_L);
      if (nstate == DRIVE_R)      cathode <= seg7(nr);
      else if (nstate == DRIVE_L) cathode <= seg7(nl);
      else                        cathode <= 7'h7F;
      // wrap into DRIVE_R marks a frame boundary; start-up from IDLE does not
      frame_tick <= (nstate == DRIVE_R) && (state != DRIVE_R) && (state != IDLE);
    end
  end

endmodule

// File: tb/tb_segment_scan_controller.sv
// Randomized bench: DUT checked against a frame-position model of the scan schedule.
module tb_segment_scan_controller;
  localparam int DW = 4;
`ifdef SEG_GHOST_BLANK_EN
  localparam int BW = 2;
`else
  localparam int BW = 0;
`endif
  localparam int FRAME = 2 * (DW + BW);

  logic clock = 1'b0, reset = 1'b1, enable = 1'b0, upd_valid = 1'b0;
  logic [3:0] right_digit = '0, left_digit = '0;
  logic upd_ready, a0, a1, frame_tick;
  logic [6:0] cathode;

  segment_scan_controller #(.DWELL_CYCLES(DW), .BLANK_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .right_digit(right_digit), .left_digit(left_digit),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .a0(a0), .a1(a1), .cathode(cathode), .frame_tick(frame_tick));

  always #5 clock = ~clock;

  logic [6:0] seg [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                          7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int total = 0, bad = 0;
  int pos = -1;            // cycle index within the frame, -1 while idle
  logic [3:0] mr = '0, ml = '0;
  logic mtick = 1'b0, xfer_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_a0(); return !(pos >= 0 && pos < DW); endfunction
  function automatic logic m_a1(); return !(pos >= DW + BW && pos < 2 * DW + BW); endfunction
  function automatic logic m_ready(); return pos < 0 || pos == FRAME - 1; endfunction

  task automatic check_outputs();
    logic [6:0] ec;
    ec = !m_a0() ? seg[mr] : (!m_a1() ? seg[ml] : 7'h7F);
    chk("a0", 32'(a0), 32'(m_a0()));
    chk("a1", 32'(a1), 32'(m_a1()));
    chk("cathode", 32'(cathode), 32'(ec));
    chk("frame_tick", 32'(frame_tick), 32'(mtick));
  endtask

  task automatic model_step();
    int old;
    xfer_last = upd_valid && m_ready();
    if (xfer_last) begin
      mr = right_digit;
      ml = left_digit;
    end
    old = pos;
    if (!enable)     pos = -1;
    else if (pos < 0) pos = 0;
    else             pos = (pos + 1) % FRAME;
    mtick = enable && old == FRAME - 1 && pos == 0;
  endtask

  task automatic model_reset();
    pos = -1; mr = '0; ml = '0; mtick = 1'b0; xfer_last = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check_outputs();
    chk("ready_in_reset", 32'(upd_ready), 32'd1);
    reset = 1'b0;
    @(negedge clock);
    check_outputs();
    // first load happens in IDLE together with enable
    enable = 1'b1; upd_valid = 1'b1; right_digit = 4'h1; left_digit = 4'h2;
    #1 chk("upd_ready", 32'(upd_ready), 32'(m_ready()));
    for (int i = 0; i < 700; i++) begin
      @(posedge clock);
      model_step();
      if (i == 230 || i == 515) begin
        #2 reset = 1'b1;
        #1 chk("async_rst_a0", 32'(a0), 32'd1);
        chk("async_rst_a1", 32'(a1), 32'd1);
        chk("async_rst_cath", 32'(cathode), 32'h7F);
        chk("async_rst_tick", 32'(frame_tick), 32'd0);
        model_reset();
        upd_valid = 1'b0;
        #1 reset = 1'b0;
      end
      @(negedge clock);
      check_outputs();
      if (xfer_last) upd_valid = 1'b0;
      if (!upd_valid && ($urandom % 5 == 0)) begin
        upd_valid = 1'b1;
        right_digit = 4'($urandom);
        left_digit = 4'($urandom);
      end
      if (i < 60)                               enable = 1'b1;
      else if (enable && ($urandom % 45 == 0))  enable = 1'b0;
      else if (!enable && ($urandom % 3 == 0))  enable = 1'b1;
      #1 chk("upd_ready", 32'(upd_ready), 32'(m_ready()));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/segment_scan_controller.md
# segment_scan_controller

Time-multiplexing scan controller for the two-digit seven-segment display on the board. It alternately drives the right digit (a0) and the left digit (a1) from two shadowed 4-bit hex values, with an optional blanking gap between digits to suppress ghosting. The parent loads new digit values through a valid/ready handshake. Loads are accepted only at frame boundaries, so a digit never changes mid-dwell. It replaces clock-level multiplexing of the anodes with a counter-driven refresh schedule.

## Interface
- DWELL_CYCLES, 100000, clock cycles each digit is driven per frame; must be ≥1
- BLANK_CYCLES, 1000, clock cycles both anodes are off after each digit (only with the blanking feature); must be ≥1
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- enable  in  1  1 = scan active, 0 = display off
- right_digit  in  4  hex value for right digit (a0)
- left_digit  in  4  hex value for left digit (a1)
- upd_valid  in  1  parent holds high with stable digit values until upd_ready
- upd_ready  out  1  high in cycles where an update is accepted
- a0  out  1  right anode, active-low
- a1  out  1  left anode, active-low
- cathode  out  7  segments a..g on bits 6..0, active-low
- frame_tick  out  1  one-cycle pulse at each frame boundary

## Operation
- States:
  - IDLE: both anodes off.
  - DRIVE_R: a0=0, a1=1, cathode shows the right shadow value.
  - BLANK_R: both anodes off.
  - DRIVE_L: a0=1, a1=0, cathode shows the left shadow value.
  - BLANK_L: both anodes off.
- Transitions:
  - IDLE→DRIVE_R when enable=1.
  - DRIVE_R→BLANK_R→DRIVE_L→BLANK_L→DRIVE_R, each on dwell-counter terminal count.
  - Without the blanking feature, BLANK states are skipped: DRIVE_R→DRIVE_L→DRIVE_R.
- enable=0 in any state → IDLE at the next edge. The counter clears and outputs blank.
- The dwell counter is sized as $clog2 of max(DWELL_CYCLES, BLANK_CYCLES). It resets to 0 on every state entry, and the terminal count is N-1.
- Whenever an anode is off, cathode = 7'b111_1111.
- Decode is hex 0–F, active-low, bit6 = segment a:
  - 1 = 1001111
  - 2 = 0010010
  - 8 = 0000000
  - F = 0111000
- Shadow registers (right, left) are 4 bits each and reset to 0.
- upd_ready is combinational and asserted in:
  - IDLE, and
  - the last cycle of a frame: the last BLANK_L cycle, or the last DRIVE_L cycle without blanking.
- A transfer occurs when upd_valid && upd_ready. The shadows capture both digits at that edge, and the new values appear from the next DRIVE_R.
- A pending upd_valid stays pending until the next frame boundary, with no loss and no duplication.
- frame_tick = 1 in the cycle following entry to DRIVE_R from BLANK_L/DRIVE_L. It does not fire on entry from IDLE.

## Timing
- Reset values: a0=1, a1=1, cathode=7'b111_1111, frame_tick=0, state IDLE, counter 0, shadows 0.
  - upd_ready follows IDLE, so it is 1 while enable=0.
- a0, a1, cathode and frame_tick are registered: they change only on clock edges or asynchronously on reset.
- Enable rises before edge k → DRIVE_R outputs visible after edge k.
- Each DRIVE state lasts exactly DWELL_CYCLES cycles; each BLANK state lasts exactly BLANK_CYCLES cycles.
- Frame period:
  - with blanking: 2·(DWELL_CYCLES+BLANK_CYCLES) cycles;
  - without blanking: 2·DWELL_CYCLES cycles.
- Update latency: from the transfer edge to the new value on the right digit is 1 cycle. The two digits never show a mix of old and new values within one frame.
- Simultaneous enable fall and transfer edge: the transfer completes and the state goes to IDLE.
- Reset asserted mid-frame: outputs take reset values without waiting for an edge; the pending handshake is dropped.
- Reset release with enable=1: DRIVE_R starts at the first edge after release.

## Configuration
- SEG_GHOST_BLANK_EN
  - Defined: BLANK_R/BLANK_L exist, and BLANK_CYCLES applies.
  - Undefined: blank states and their logic are compiled out. The anodes switch directly between digits, and BLANK_CYCLES is ignored.

## Test plan
All scenarios use DWELL_CYCLES=4, BLANK_CYCLES=2.
- Reset, then enable=1, right=1, left=2 loaded in IDLE → repeating 12-cycle frame:
  - 4 cycles a0=0, cathode=1001111;
  - 2 cycles blank (cathode 1111111);
  - 4 cycles a1=0, cathode=0010010;
  - 2 cycles blank.
- upd_valid raised mid-DRIVE_R with right=8, left=F → upd_ready only in the last BLANK_L cycle. The next frame shows 0000000 then 0111000, and no frame mixes old and new values.
- frame_tick → one-cycle pulse exactly every 12 cycles, none on first entry from IDLE.
- enable dropped during DRIVE_L → next edge a0=a1=1, cathode all 1s. Re-enable restarts at DRIVE_R with a full 4-cycle dwell.
- reset pulsed asynchronously (between edges) mid-frame → outputs go to reset values immediately and shadows read 0 after release.
- Compiled without SEG_GHOST_BLANK_EN → 8-cycle frame, a0/a1 toggling every 4 cycles, with no all-off cycles while enabled.
